// File: rtl/switch_scheduler.sv
// 4x4 input-queued packet switch: one FIFO per input port, one round-robin
// arbiter per output port, registered outputs and saturating drop counters.
module switch_scheduler #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  valid_in,
    input  logic [15:0] source_in,
    input  logic [15:0] target_in,
    input  logic [31:0] data_in,
    output logic [3:0]  ready_in,
    output logic [3:0]  valid_out,
    output logic [15:0] source_out,
    output logic [15:0] target_out,
    output logic [31:0] data_out,
    output logic [31:0] drop_cnt
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic [3:0] source;
        logic [3:0] target;
        logic [7:0] data;
    } pkt_t;

    pkt_t          mem [4][FIFO_DEPTH];
    logic [PW-1:0] wr_ptr [4];
    logic [PW-1:0] rd_ptr [4];
    logic [CW-1:0] count  [4];
    logic [1:0]    rr_ptr [4];

    pkt_t       in_pkt [4];
    pkt_t       head   [4];
    logic [3:0] target_ok;
    logic [3:0] push;
    logic [3:0] drop;
    logic [3:0] pop;
    logic [3:0] nonempty;
    logic [3:0] req    [4];
    logic [3:0] grant_vec;
    logic [1:0] winner [4];

    function automatic logic [1:0] rr_idx(input logic [1:0] p, input int k);
        rr_idx = p + k[1:0];
    endfunction

    // Input side: acceptance depends only on registered occupancy, so a full
    // queue rejects a push even when it is popped at the same edge.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            in_pkt[i].source = source_in[4*i +: 4];
            in_pkt[i].target = target_in[4*i +: 4];
            in_pkt[i].data   = data_in[8*i +: 8];
            target_ok[i] = (in_pkt[i].target != 4'b0000) &&
                           ((in_pkt[i].target & (in_pkt[i].target - 4'd1)) == 4'b0000);
            ready_in[i]  = (count[i] != FULL);
            push[i]      = valid_in[i] && ready_in[i] && target_ok[i];
            drop[i]      = valid_in[i] && !(ready_in[i] && target_ok[i]);
            nonempty[i]  = (count[i] != '0);
            head[i]      = mem[i][rd_ptr[i]];
        end
    end

    // Request matrix indexed [output][input]; a queue being written while
    // empty is not yet nonempty, so it cannot be granted this cycle.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 4; i++) begin
                req[j][i] = nonempty[i] && head[i].target[j];
            end
        end
    end

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            grant_vec[j] = 1'b0;
            winner[j]    = 2'd0;
            for (int k = 0; k < 4; k++) begin
                if (!grant_vec[j] && req[j][rr_idx(rr_ptr[j], k)]) begin
                    grant_vec[j] = 1'b1;
                    winner[j]    = rr_idx(rr_ptr[j], k);
                end
            end
        end
    end

    // A head targets exactly one output, so at most one term is set per queue.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pop[i] = 1'b0;
            for (int j = 0; j < 4; j++) begin
                if (grant_vec[j] && (winner[j] == 2'(i))) begin
                    pop[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= in_pkt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            drop_cnt <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                end
                if (push[i] && !pop[i]) begin
                    count[i] <= count[i] + CW'(1);
                end else if (!push[i] && pop[i]) begin
                    count[i] <= count[i] - CW'(1);
                end
                if (drop[i] && (drop_cnt[8*i +: 8] != 8'hFF)) begin
                    drop_cnt[8*i +: 8] <= drop_cnt[8*i +: 8] + 8'd1;
                end
            end
        end
    end

    // Output registers: data lanes keep their last value when no grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < 4; j++) begin
                rr_ptr[j] <= 2'd0;
            end
            valid_out  <= '0;
            source_out <= '0;
            target_out <= '0;
            data_out   <= '0;
        end else begin
            for (int j = 0; j < 4; j++) begin
                valid_out[j] <= grant_vec[j];
                if (grant_vec[j]) begin
                    rr_ptr[j]            <= winner[j] + 2'd1;
                    source_out[4*j +: 4] <= head[winner[j]].source;
                    target_out[4*j +: 4] <= head[winner[j]].target;
                    data_out[8*j +: 8]   <= head[winner[j]].data;
                end
            end
        end
    end

endmodule

// File: doc/switch_scheduler.md
SWITCH_SCHEDULER -- requirements
Module: switch_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning entries per input queue; legal values are powers of two, 2..16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, with all state on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port valid_in, input, 4 bits: bit i means input port i presents a packet this cycle.
REQ-005 SHALL have port source_in, input, 16 bits: port i source field in bits [4i+3:4i].
REQ-006 SHALL have port target_in, input, 16 bits: port i one-hot destination field in bits [4i+3:4i].
REQ-007 SHALL have port data_in, input, 32 bits: port i payload byte in bits [8i+7:8i].
REQ-008 SHALL have port ready_in, output, 4 bits: bit i high means queue i is not full.
REQ-009 SHALL have port valid_out, output, 4 bits: bit j high means output port j carries a packet this cycle.
REQ-010 SHALL have ports source_out (16 bits), target_out (16 bits) and data_out (32 bits), outputs, with the same lane packing as the inputs.
REQ-011 SHALL have port drop_cnt, output, 32 bits: port i 8-bit saturating drop counter in bits [8i+7:8i].

Function
REQ-012 SHALL give each input port a FIFO of FIFO_DEPTH entries {source, target, data}.
REQ-013 SHALL write a packet into queue i at an edge where valid_in[i]=1, ready_in[i]=1 and target_in lane i is one-hot.
REQ-014 SHALL drop, and not enqueue, a packet where valid_in[i]=1 and either ready_in[i]=0 or the target is not one-hot (including 0); each such packet increments drop counter i by 1, saturating at 255.
REQ-015 SHALL drive ready_in[i] from registered occupancy only: ready_in[i] = (count_i != FIFO_DEPTH).
REQ-016 SHALL NOT accept a push to a full queue in the same cycle as a pop; it is dropped per REQ-014.
REQ-017 SHALL compute the requests to output j each cycle: the set of non-empty queues whose head target has bit j set.
REQ-018 SHALL give each output j a round-robin arbiter with a 2-bit pointer p_j, where priority order is p_j, p_j+1, ... mod 4.
REQ-019 SHALL set p_j to (winner+1) mod 4 on a grant; with no grant, p_j holds.
REQ-020 SHALL make grants independent across outputs: each queue's head requests exactly one output, so each queue pops at most once per cycle.
REQ-021 SHALL pop the winning queue's head at the grant edge.
REQ-022 SHALL, at the same edge, register the head into output j: valid_out[j]=1, with source_out, target_out and data_out lane j equal to the head fields unchanged.
REQ-023 SHALL clear valid_out[j] at any edge with no grant for output j; data lanes then hold their last values.
REQ-024 SHALL meet this latency: a packet sampled at edge k into an empty queue with no contention has valid_out high in the cycle after edge k+1, for one cycle.
REQ-025 SHALL sustain throughput of one packet per output per cycle; a queue drains at one per cycle while it wins.
REQ-026 SHALL handle simultaneous push and pop on the same queue in one cycle, leaving count unchanged; a FIFO that is both empty and being written SHALL NOT be granted that cycle.
REQ-027 SHALL wrap FIFO pointers modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.

Reset
REQ-028 SHALL, while rst_n=0 and independent of clk, set FIFO pointers and counts to 0, all p_j to 0, valid_out to 0, source_out, target_out and data_out to 0, and drop_cnt to 0.
REQ-029 SHALL have ready_in=4'b1111 during and after reset.
REQ-030 SHALL discard queued packets when reset asserts mid-operation; none appear after reset releases.
REQ-031 SHALL accept no push at the first edge after rst_n rises only if valid_in=0; otherwise normal rules apply.

Verification
REQ-032 SHALL cover single packet: port 2 sends source=4'h4, target=4'b0001, data=8'hA5 -> valid_out[0]=1 with the same fields 2 cycles later, and other outputs idle.
REQ-033 SHALL cover contention: ports 0..3 all target 4'b1000 for one cycle -> output 3 emits ports 0,1,2,3 on consecutive cycles; a second burst emits 0,1,2,3 again.
REQ-034 SHALL cover parallel traffic: port i targets output (i+1) mod 4, all in the same cycle -> all four valid_out high together 2 cycles later.
REQ-035 SHALL cover overflow: port 1 sends 6 packets on back-to-back cycles to output 2 while port 0 streams to output 2 -> ready_in[1] drops at FIFO_DEPTH, each rejected packet increments drop_cnt[15:8], and accepted packets exit in order.
REQ-036 SHALL cover bad target: target=4'b0110 or 4'b0000 -> no output and drop count +1; 300 bad packets -> counter saturates at 8'hFF.
REQ-037 SHALL cover mid-operation reset: rst_n=0 with 3 packets queued -> all outputs 0 immediately, and no stale packet emitted after release.
